// File: rtl/dlx_exec_unit.sv
// DLX execute stage: operand select, ALU, shifter, load/store address path and an
// iterative shift-add multiplier behind a valid/ready handshake with a registered
// result stage.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   enable_ex               global enable; low freezes every register
//   in_valid / in_ready     operation handshake (accept = in_valid & in_ready)
//   src1, src2, imm         operand A, operand B / store data, immediate
//   mem_data_read_in        load data, captured at accept
//   control_in              [6:4] operation, [3] immediate select, [2:0] opselect
//   out_valid / out_ready   result handshake
//   aluout                  result or effective address
//   mem_data_write_out/_en  store data and strobe (strobe meaningful with out_valid)
//   carry                   carry / borrow / multiply-overflow flag
//   busy                    multiply in progress
module dlx_exec_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_ex,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mem_data_read_in,
  input  logic [6:0]       control_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] mem_data_write_out,
  output logic             mem_data_write_en,
  output logic             carry,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CntLast = (SHW + 1)'(WIDTH);

  localparam logic [2:0] OpShift = 3'b000;
  localparam logic [2:0] OpArith = 3'b001;
  localparam logic [2:0] OpStore = 3'b100;
  localparam logic [2:0] OpLoad  = 3'b101;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   aluout_q, aluout_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               carry_q, carry_d;
  logic               out_valid_q, out_valid_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;

  logic [2:0]       op, sel;
  logic [WIDTH-1:0] op_b;
  logic [SHW-1:0]   shamt;
  logic             accept, is_mul;
  logic [WIDTH-1:0] res, res_wdata;
  logic             res_c, res_we;
  logic [WIDTH:0]   mul_sum;
  logic signed [WIDTH:0] sra_tmp;

  assign op     = control_in[6:4];
  assign sel    = control_in[2:0];
  assign op_b   = control_in[3] ? imm : src2;
  assign shamt  = op_b[SHW-1:0];
  assign is_mul = MUL_EN && (op == OpArith) && (sel == 3'b111);

  assign in_ready = enable_ex && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle result; MUL and undefined encodings fall through as NOP (all zero).
  always_comb begin
    res       = '0;
    res_c     = 1'b0;
    res_we    = 1'b0;
    res_wdata = '0;
    sra_tmp   = '0;
    unique case (op)
      OpArith: begin
        unique case (sel)
          3'b000: {res_c, res} = {1'b0, src1} + {1'b0, op_b};
          3'b001: begin
            res   = src1 - op_b;
            res_c = src1 < op_b;
          end
          3'b010: res = src1 & op_b;
          3'b011: res = src1 | op_b;
          3'b100: res = src1 ^ op_b;
          3'b101: res = ~src1;
          3'b110: res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(op_b)};
          default: ;
        endcase
      end
      OpShift: begin
        // One guard bit beyond the datapath catches the last bit shifted out;
        // a zero shift leaves the guard bit clear.
        unique case (sel)
          3'b000: {res_c, res} = {1'b0, src1} << shamt;
          3'b001: {res, res_c} = {src1, 1'b0} >> shamt;
          3'b010: begin
            sra_tmp      = $signed({src1, 1'b0}) >>> shamt;
            {res, res_c} = sra_tmp;
          end
          default: ;
        endcase
      end
      OpStore: begin
        res       = src1 + imm;
        res_we    = 1'b1;
        res_wdata = src2;
      end
      OpLoad:  res = mem_data_read_in;
      default: ;
    endcase
  end

  // Shift-add step: add multiplicand into the upper half when the LSB is set, then shift right.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    state_d     = state_q;
    aluout_d    = aluout_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_mul) begin
          // Accept implies any held result retires this cycle.
          state_d     = StMul;
          cnt_d       = '0;
          prod_d      = {{WIDTH{1'b0}}, op_b};
          mcand_d     = src1;
          out_valid_d = 1'b0;
          we_d        = 1'b0;
        end else if (accept) begin
          aluout_d    = res;
          carry_d     = res_c;
          we_d        = res_we;
          wdata_d     = res_wdata;
          out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          we_d        = 1'b0;
        end
      end
      StMul: begin
        // WIDTH iterations, then one cycle to move the product into the output stage.
        if (cnt_q == CntLast) begin
          aluout_d    = prod_q[WIDTH-1:0];
          carry_d     = |prod_q[2*WIDTH-1:WIDTH];
          we_d        = 1'b0;
          wdata_d     = '0;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      aluout_q    <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
    end else if (enable_ex) begin
      state_q     <= state_d;
      aluout_q    <= aluout_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
    end
  end

  assign aluout             = aluout_q;
  assign mem_data_write_out = wdata_q;
  assign mem_data_write_en  = we_q;
  assign carry              = carry_q;
  assign out_valid          = out_valid_q;
  assign busy               = (state_q == StMul);

endmodule

// File: tb/tb_dlx_exec_unit.sv
module tb_dlx_exec_unit;

  logic        clk = 1'b0;
  logic        reset, enable_ex, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src1, src2, imm, mem_data_read_in, aluout, mem_data_write_out;
  logic [6:0]  control_in;
  logic        mem_data_write_en, carry, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dlx_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_ex          (enable_ex),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .src1               (src1),
    .src2               (src2),
    .imm                (imm),
    .mem_data_read_in   (mem_data_read_in),
    .control_in         (control_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .aluout             (aluout),
    .mem_data_write_out (mem_data_write_out),
    .mem_data_write_en  (mem_data_write_en),
    .carry              (carry),
    .busy               (busy)
  );

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] a, b, im, exp;
    logic        c;
  } vec_t;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    control_in = ctl;
    src1       = a;
    src2       = b;
    imm        = im;
    in_valid   = 1'b1;
  endtask

  task automatic test_reset();
    step();
    step();
    vectors++;
    if ({aluout, mem_data_write_out, carry, mem_data_write_en, out_valid, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: aluout=%h wdata=%h c=%b we=%b ov=%b busy=%b, want all 0",
               aluout, mem_data_write_out, carry, mem_data_write_en, out_valid, busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_alu_shift();
    vec_t vq[$];
    vq.push_back('{7'b001_0_000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1});        // ADD
    vq.push_back('{7'b001_0_001, 32'h5, 32'h7, 32'h0, 32'hFFFF_FFFE, 1'b1});        // SUB borrow
    vq.push_back('{7'b001_0_001, 32'h7, 32'h5, 32'h0, 32'h2, 1'b0});                // SUB
    vq.push_back('{7'b001_0_010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h00F0_00F0, 1'b0});
    vq.push_back('{7'b001_0_011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'hFFF0_FFF0, 1'b0});
    vq.push_back('{7'b001_0_100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'hFF00_FF00, 1'b0});
    vq.push_back('{7'b001_0_101, 32'hF0F0_F0F0, 32'h0, 32'h0, 32'h0F0F_0F0F, 1'b0}); // NOT A
    vq.push_back('{7'b001_0_110, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 1'b0});        // SLT -1<1
    vq.push_back('{7'b001_0_110, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0});        // SLT 1<-1
    vq.push_back('{7'b001_1_000, 32'd10, 32'd99, 32'd20, 32'd30, 1'b0});            // ADD imm
    vq.push_back('{7'b000_1_010, 32'h8000_0000, 32'h0, 32'h4, 32'hF800_0000, 1'b0}); // SRA 4
    vq.push_back('{7'b000_0_000, 32'h8000_0001, 32'h1, 32'h0, 32'h2, 1'b1});        // SLL 1
    vq.push_back('{7'b000_0_001, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678, 1'b0}); // SRL 0
    vq.push_back('{7'b000_0_001, 32'h0000_000F, 32'h4, 32'h0, 32'h0, 1'b1});        // SRL 4
    vq.push_back('{7'b000_0_011, 32'h1234_5678, 32'h1, 32'h0, 32'h0, 1'b0});        // shift NOP
    vq.push_back('{7'b001_0_000, 32'h1, 32'h2, 32'h0, 32'h3, 1'b0});                // ADD
    vq.push_back('{7'b111_0_000, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0});                // bad op NOP
    out_ready = 1'b1;
    foreach (vq[i]) begin
      drive(vq[i].ctl, vq[i].a, vq[i].b, vq[i].im);
      step();
      vectors++;
      if (aluout !== vq[i].exp || carry !== vq[i].c || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL alu_vec%0d: aluout=%h c=%b ov=%b want %h c=%b ov=1",
                 i, aluout, carry, out_valid, vq[i].exp, vq[i].c);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_mul();
    logic [31:0] a_v [2] = '{32'h0001_0000, 32'd7};
    logic [31:0] b_v [2] = '{32'h0001_0000, 32'd6};
    logic [31:0] p_v [2] = '{32'h0, 32'd42};
    logic        c_v [2] = '{1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int k = 0;
      logic bad = 1'b0;
      drive(7'b001_0_111, a_v[i], b_v[i], 32'h0);
      step();
      in_valid = 1'b0;
      while (!out_valid && k < 100) begin
        if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        step();
        k++;
      end
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL mul%0d_busy: busy/in_ready wrong during multiply", i);
      end
      vectors++;
      if (k != 33) begin
        miscompares++;
        $display("FAIL mul%0d_latency: out_valid after %0d edges want 33", i, k);
      end
      vectors++;
      if (aluout !== p_v[i] || carry !== c_v[i] || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mul%0d_result: aluout=%h c=%b busy=%b want %h c=%b busy=0",
                 i, aluout, carry, busy, p_v[i], c_v[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic bad = 1'b0;
    out_ready = 1'b0;
    drive(7'b001_0_000, 32'd1, 32'd2, 32'h0);
    step();
    drive(7'b001_0_000, 32'd10, 32'd20, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0) bad = 1'b1;
      step();
      if (aluout !== 32'd3 || out_valid !== 1'b1) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL b2b_stall: aluout=%h ov=%b in_ready=%b want 3/1/0 while stalled",
               aluout, out_valid, in_ready);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_release_ready: in_ready=%b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (aluout !== 32'd30 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: aluout=%h ov=%b want 0000001e/1", aluout, out_valid);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_dup: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_store_load();
    out_ready = 1'b0;
    drive(7'b100_0_000, 32'h100, 32'hDEAD_BEEF, 32'h8);
    step();
    in_valid = 1'b0;
    vectors++;
    if (aluout !== 32'h108 || mem_data_write_out !== 32'hDEAD_BEEF ||
        mem_data_write_en !== 1'b1 || carry !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL store: aluout=%h wdata=%h we=%b c=%b ov=%b want 108/deadbeef/1/0/1",
               aluout, mem_data_write_out, mem_data_write_en, carry, out_valid);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (mem_data_write_en !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL store_retire: we=%b ov=%b want 0/0", mem_data_write_en, out_valid);
    end
    mem_data_read_in = 32'h1234;
    drive(7'b101_0_000, 32'h55, 32'h66, 32'h77);
    step();
    in_valid = 1'b0;
    mem_data_read_in = 32'h9999;
    vectors++;
    if (aluout !== 32'h1234 || mem_data_write_en !== 1'b0 || carry !== 1'b0) begin
      miscompares++;
      $display("FAIL load: aluout=%h we=%b c=%b want 1234/0/0", aluout, mem_data_write_en, carry);
    end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    drive(7'b001_0_111, 32'd7, 32'd6, 32'h0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b0;
    step();
    vectors++;
    if ({aluout, mem_data_write_out, carry, mem_data_write_en, out_valid, busy} !== '0) begin
      miscompares++;
      $display("FAIL mul_reset: aluout=%h c=%b ov=%b busy=%b want all 0",
               aluout, carry, out_valid, busy);
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) step();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_abort: ov=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_enable();
    int k = 0;
    out_ready = 1'b1;
    drive(7'b001_0_111, 32'd9, 32'd5, 32'h0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      k++;
    end
    enable_ex = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_in_ready: in_ready=%b want 0", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      k++;
    end
    vectors++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_frozen: busy=%b ov=%b want 1/0", busy, out_valid);
    end
    enable_ex = 1'b1;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
    vectors++;
    if (k != 37 || aluout !== 32'd45) begin
      miscompares++;
      $display("FAIL enable_latency: %0d edges aluout=%h want 37 edges aluout=0000002d",
               k, aluout);
    end
  endtask

  initial begin
    reset            = 1'b0;
    enable_ex        = 1'b1;
    in_valid         = 1'b0;
    out_ready        = 1'b1;
    src1             = '0;
    src2             = '0;
    imm              = '0;
    mem_data_read_in = '0;
    control_in       = '0;
    test_reset();
    test_alu_shift();
    test_mul();
    test_back_to_back();
    test_store_load();
    test_reset_mid_mul();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
